// File: rtl/mmu_data_port_if.sv
// -----------------------------------------------------------------------------
// mmu_data_port_if
// Bundles the MEM-stage request/response signals and the backing-RAM port of
// the MMU data port.
//   MEM side : mem_valid, mem_we, mem_size, mem_addr, mem_wdata  (to MMU)
//              mmu_data_ready, mmu_rdata, mmu_fault              (from MMU)
//   RAM side : ram_req, ram_we, ram_addr, ram_wdata, ram_wmask   (from MMU)
//              ram_ack, ram_rdata                                (to MMU)
// Modports:
//   slave  - the MMU data port itself
//   master - the environment (pipeline MEM stage plus backing RAM)
// -----------------------------------------------------------------------------
interface mmu_data_port_if #(
   parameter int ADDR_W = 64
);
   logic              mem_valid;
   logic              mem_we;
   logic [2:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;

   logic              mmu_data_ready;
   logic [63:0]       mmu_rdata;
   logic              mmu_fault;

   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [63:0]       ram_wdata;
   logic [7:0]        ram_wmask;
   logic              ram_ack;
   logic [63:0]       ram_rdata;

   modport slave (
      input  mem_valid, mem_we, mem_size, mem_addr, mem_wdata,
      output mmu_data_ready, mmu_rdata, mmu_fault,
      output ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
      input  ram_ack, ram_rdata
   );

   modport master (
      output mem_valid, mem_we, mem_size, mem_addr, mem_wdata,
      input  mmu_data_ready, mmu_rdata, mmu_fault,
      input  ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
      output ram_ack, ram_rdata
   );
endinterface

// File: rtl/mmu_data_port.sv
// -----------------------------------------------------------------------------
// mmu_data_port
// Turns a MEM-stage load/store into a single doubleword access on a backing
// RAM. Requests are latched in IDLE, checked for natural alignment, issued to
// the RAM in ACCESS (held until ram_ack), and completed with a one-cycle
// mmu_data_ready pulse in RESP. Misaligned requests skip the RAM and complete
// with mmu_fault.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - mmu_data_port_if.slave (MEM request/response and RAM port)
// -----------------------------------------------------------------------------
module mmu_data_port #(
   parameter int ADDR_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   mmu_data_port_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   // funct3 size encodings
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_D  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;
   localparam logic [2:0] SZ_WU = 3'b110;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic              fault_q, fault_d;
   logic [63:0]       rdata_q, rdata_d;

   logic [2:0]        offset;
   logic [5:0]        lane_shift;
   logic [63:0]       load_shifted;
   logic [63:0]       load_ext;

   // Natural alignment: halfwords on 2, words on 4, doublewords on 8 bytes.
   // The unused encoding 3'b111 is treated as a byte access.
   function automatic logic is_misaligned(input logic [2:0] size,
                                          input logic [2:0] off);
      logic mis;
      case (size)
         SZ_H, SZ_HU: mis = off[0];
         SZ_W, SZ_WU: mis = |off[1:0];
         SZ_D:        mis = |off;
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [7:0] size_mask(input logic [2:0] size);
      logic [7:0] m;
      case (size)
         SZ_H, SZ_HU: m = 8'h03;
         SZ_W, SZ_WU: m = 8'h0F;
         SZ_D:        m = 8'hFF;
         default:     m = 8'h01;
      endcase
      return m;
   endfunction

   // ------------------------------------------------------------------------
   // Lane positioning, all derived from the latched request so the RAM sees
   // stable values for the whole ACCESS phase.
   // ------------------------------------------------------------------------
   assign offset       = addr_q[2:0];
   assign lane_shift   = {offset, 3'b000};
   assign load_shifted = bus.ram_rdata >> lane_shift;

   always_comb begin
      case (size_q)
         SZ_B:    load_ext = {{56{load_shifted[7]}},  load_shifted[7:0]};
         SZ_H:    load_ext = {{48{load_shifted[15]}}, load_shifted[15:0]};
         SZ_W:    load_ext = {{32{load_shifted[31]}}, load_shifted[31:0]};
         SZ_BU:   load_ext = {56'd0, load_shifted[7:0]};
         SZ_HU:   load_ext = {48'd0, load_shifted[15:0]};
         SZ_WU:   load_ext = {32'd0, load_shifted[31:0]};
         default: load_ext = load_shifted;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fault_d = fault_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (bus.mem_valid) begin
               we_d   = bus.mem_we;
               size_d = bus.mem_size;
               addr_d = bus.mem_addr;
               if (bus.mem_we) begin
                  wdata_d = bus.mem_wdata;
               end
               fault_d = is_misaligned(bus.mem_size, bus.mem_addr[2:0]);
               if (fault_d) begin
                  // Fault completes without touching the RAM; the response
                  // data is defined as zero.
                  rdata_d = 64'd0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end

         S_ACCESS: begin
            if (bus.ram_ack) begin
               rdata_d = we_q ? 64'd0 : load_ext;
               state_d = S_RESP;
            end
         end

         S_RESP: begin
            // Any mem_valid seen here belongs to the next transaction and is
            // picked up once back in IDLE.
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State and request registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every register here, including the datapath latches, is
         // reset so the RAM address/data outputs come up at a known zero.
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 64'd0;
         fault_q <= 1'b0;
         rdata_q <= 64'd0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from
         // the values present before the edge, independent of statement order.
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.ram_req   = (state_q == S_ACCESS);
   assign bus.ram_we    = bus.ram_req & we_q;
   assign bus.ram_addr  = {addr_q[ADDR_W-1:3], 3'b000};
   assign bus.ram_wdata = wdata_q << lane_shift;
   assign bus.ram_wmask = we_q ? (size_mask(size_q) << offset) : 8'h00;

   assign bus.mmu_data_ready = (state_q == S_RESP);
   assign bus.mmu_fault      = bus.mmu_data_ready & fault_q;
   assign bus.mmu_rdata      = rdata_q;

endmodule

// File: tb/tb_mmu_data_port.sv
// -----------------------------------------------------------------------------
// tb_mmu_data_port
// Directed bench for mmu_data_port. Expected completions are queued when a
// request is driven and popped when mmu_data_ready is seen.
// -----------------------------------------------------------------------------
module tb_mmu_data_port;

   localparam int          ADDR_W = 64;
   localparam logic [63:0] RD     = 64'h8877665544332211;

   typedef struct {
      string       tag;
      logic [63:0] rdata;
      logic        fault;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mmu_data_port_if #(.ADDR_W(ADDR_W)) bus ();

   mmu_data_port #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [63:0] lane_bits(input logic [7:0] m);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   // Pops the oldest expectation and compares it with the current response.
   task automatic score(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_unexpected_ready"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_rdata"}, bus.mmu_rdata, e.rdata);
         check({e.tag, "_fault"}, {63'd0, bus.mmu_fault}, {63'd0, e.fault});
      end
   endtask

   // Called at a negedge; returns at a negedge one cycle after the ready pulse.
   task automatic run_txn(input string tag, input logic we,
                          input logic [2:0] size, input logic [63:0] addr,
                          input logic [63:0] wdata, input int ack_delay,
                          input logic [63:0] exp_rdata, input logic exp_fault,
                          input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata, input int exp_lat);
      exp_t        e;
      int          req_cycles = 0;
      int          lat        = -1;
      logic        stable     = 1'b1;
      logic [63:0] first_addr = '0;
      logic [63:0] first_wd   = '0;
      logic [7:0]  first_mask = '0;

      bus.mem_valid = 1'b1;
      bus.mem_we    = we;
      bus.mem_size  = size;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = RD;
      e.tag = tag; e.rdata = exp_rdata; e.fault = exp_fault;
      sb.push_back(e);

      @(posedge clk);  // acceptance edge
      @(negedge clk);
      // Drop and scramble the request; the latched copy must be used.
      bus.mem_valid = 1'b0;
      bus.mem_we    = ~we;
      bus.mem_size  = 3'b011;
      bus.mem_addr  = 64'hDEAD_BEEF_0000_0003;
      bus.mem_wdata = '1;

      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         if (bus.mmu_data_ready) begin
            lat = k;
            break;
         end
         if (bus.ram_req) begin
            req_cycles++;
            if (req_cycles == 1) begin
               first_addr = bus.ram_addr;
               first_wd   = bus.ram_wdata;
               first_mask = bus.ram_wmask;
               check({tag, "_ram_addr"}, bus.ram_addr, addr & ~64'h7);
               check({tag, "_ram_wmask"}, {56'd0, bus.ram_wmask},
                     {56'd0, exp_mask});
               check({tag, "_ram_we"}, {63'd0, bus.ram_we}, {63'd0, we});
               if (we)
                  check({tag, "_ram_wdata"},
                        bus.ram_wdata & lane_bits(exp_mask),
                        exp_wdata & lane_bits(exp_mask));
            end else if (bus.ram_addr !== first_addr ||
                         bus.ram_wdata !== first_wd ||
                         bus.ram_wmask !== first_mask) begin
               stable = 1'b0;
            end
            bus.ram_ack = (req_cycles > ack_delay);
         end else begin
            bus.ram_ack = 1'b0;
         end
      end
      bus.ram_ack = 1'b0;

      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      if (lat > 0) score(tag);
      check({tag, "_req_cycles"}, 64'(req_cycles),
            exp_fault ? 64'd0 : 64'(ack_delay + 1));
      if (req_cycles > 1)
         check({tag, "_req_stable"}, {63'd0, stable}, 64'd1);

      @(negedge clk);
      check({tag, "_single_pulse"},
            {62'd0, bus.mmu_data_ready, bus.mmu_fault}, 64'd0);
      check({tag, "_rdata_hold"}, bus.mmu_rdata, exp_rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pulses;
      logic prev_ready;
      exp_t e;

      rst           = 1'b1;
      bus.mem_valid = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 3'd0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = '0;

      // ---------------- reset state ----------------
      #12;
      check("rst_ctrl", {59'd0, bus.mmu_data_ready, bus.mmu_fault,
                         bus.ram_req, bus.ram_we, 1'b0}, 64'd0);
      check("rst_wmask", {56'd0, bus.ram_wmask}, 64'd0);
      check("rst_rdata", bus.mmu_rdata, 64'd0);
      check("rst_ram_addr", bus.ram_addr, 64'd0);
      check("rst_ram_wdata", bus.ram_wdata, 64'd0);

      // First request accepted on the first edge after reset release.
      @(negedge clk);
      rst = 1'b0;

      // ---------------- loads ----------------
      run_txn("ld_1000",  0, 3'b011, 64'h1000, 0, 0, RD,                    0, 8'h00, 0, 2);
      run_txn("lb_1005",  0, 3'b000, 64'h1005, 0, 0, 64'h0000000000000066,  0, 8'h00, 0, 2);
      run_txn("lh_1006",  0, 3'b001, 64'h1006, 0, 0, 64'hFFFFFFFFFFFF8877,  0, 8'h00, 0, 2);
      run_txn("lwu_1004", 0, 3'b110, 64'h1004, 0, 0, 64'h0000000088776655,  0, 8'h00, 0, 2);
      // Misaligned word: no RAM access, fault, zero data.
      run_txn("lw_3002_fault", 0, 3'b010, 64'h3002, 0, 0, 64'd0,            1, 8'h00, 0, 1);
      run_txn("lb_1007",  0, 3'b000, 64'h1007, 0, 1, 64'hFFFFFFFFFFFFFF88,  0, 8'h00, 0, 3);
      run_txn("lw_1004",  0, 3'b010, 64'h1004, 0, 0, 64'hFFFFFFFF88776655,  0, 8'h00, 0, 2);

      // ---------------- stores ----------------
      run_txn("sh_2002",  1, 3'b001, 64'h2002, 64'hABCD, 3, 64'd0, 0, 8'h0C,
              64'h00000000ABCD0000, 5);
      run_txn("sd_2000",  1, 3'b011, 64'h2000, 64'h0123456789ABCDEF, 0, 64'd0, 0,
              8'hFF, 64'h0123456789ABCDEF, 2);
      run_txn("sb_2007",  1, 3'b000, 64'h2007, 64'h5A, 2, 64'd0, 0, 8'h80,
              64'h5A00000000000000, 4);

      run_txn("lbu_1007", 0, 3'b100, 64'h1007, 0, 0, 64'h0000000000000088,  0, 8'h00, 0, 2);
      run_txn("lhu_1001_fault", 0, 3'b101, 64'h1001, 0, 0, 64'd0,           1, 8'h00, 0, 1);
      run_txn("ld_3004_fault",  0, 3'b011, 64'h3004, 0, 0, 64'd0,           1, 8'h00, 0, 1);

      // ---------------- reset during ACCESS ----------------
      bus.mem_valid = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 3'b011;
      bus.mem_addr  = 64'h4008;
      bus.ram_rdata = RD;
      @(posedge clk);
      @(negedge clk);
      bus.mem_valid = 1'b0;
      check("rstacc_req_before", {63'd0, bus.ram_req}, 64'd1);
      rst = 1'b1;
      #1;
      check("rstacc_req_dropped", {63'd0, bus.ram_req}, 64'd0);
      check("rstacc_ram_addr", bus.ram_addr, 64'd0);
      bus.ram_ack = 1'b1;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.mmu_data_ready) pulses++;
      end
      rst         = 1'b0;
      bus.ram_ack = 1'b0;
      @(negedge clk);
      if (bus.mmu_data_ready) pulses++;
      check("rstacc_no_ready", 64'(pulses), 64'd0);
      run_txn("lb_after_rst", 0, 3'b000, 64'h1005, 0, 0, 64'h66, 0, 8'h00, 0, 2);

      // ---------------- back-to-back with mem_valid held ----------------
      // ram_ack is held high throughout, so it is also present in IDLE/RESP.
      bus.mem_valid = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 3'b011;
      bus.mem_addr  = 64'h1000;
      bus.ram_rdata = RD;
      bus.ram_ack   = 1'b1;
      e.tag = "b2b_ld"; e.rdata = RD; e.fault = 1'b0;
      sb.push_back(e);
      pulses     = 0;
      prev_ready = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.mmu_data_ready) begin
            if (prev_ready)
               check("b2b_ready_consecutive", 64'd1, 64'd0);
            pulses++;
            score("b2b");
            if (pulses == 1) begin
               // Changed while in RESP; becomes the second transaction.
               bus.mem_size = 3'b000;
               bus.mem_addr = 64'h1005;
               e.tag = "b2b_lb"; e.rdata = 64'h66; e.fault = 1'b0;
               sb.push_back(e);
            end else begin
               bus.mem_valid = 1'b0;
            end
         end
         prev_ready = bus.mmu_data_ready;
      end
      bus.ram_ack = 1'b0;
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
